// File: rtl/operand_entry.sv
// Hex operand entry: debounced ENTER/BACK buttons drive a 3-state FSM.
// The FSM commits an 8-bit operand one nibble at a time.
module operand_entry #(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int CNT_W           = 17
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] buttons,
  input  logic [3:0] switches,
  output logic [7:0] operand,
  output logic       operand_valid,
  output logic [1:0] state,
  output logic [3:0] disp_hi,
  output logic [3:0] disp_lo
);

  typedef enum logic [1:0] {
    S_HI   = 2'd0,
    S_LO   = 2'd1,
    S_DONE = 2'd2,
    S_BAD  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]            r_sync1, r_sync2, r_deb, r_deb_d;
  logic [1:0][CNT_W-1:0] r_cnt;
  logic                  w_enter, w_back;

  state_t     r_state;
  logic [3:0] r_hi, r_lo;
  logic [7:0] r_operand;
  logic       r_valid;

  // Levels are kept as "pressed = 1" after the inversion at the synchronizer input.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      r_deb_d <= '0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= ~buttons;
      r_sync2 <= r_sync1;
      r_deb_d <= r_deb;
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] != r_deb[i]) begin
          if (r_cnt[i] == CNT_LAST) begin
            r_deb[i] <= r_sync2[i];
            r_cnt[i] <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + 1'b1;
          end
        end else begin
          r_cnt[i] <= '0;
        end
      end
    end
  end

  assign w_back  = r_deb[1] & ~r_deb_d[1];
  assign w_enter = r_deb[0] & ~r_deb_d[0] & ~w_back;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_HI;
      r_hi      <= '0;
      r_lo      <= '0;
      r_operand <= '0;
      r_valid   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_HI: begin
          if (w_back) begin
            r_hi <= '0;
          end else if (w_enter) begin
            r_hi    <= switches;
            r_state <= S_LO;
          end
        end
        S_LO: begin
          if (w_back) begin
            r_hi    <= '0;
            r_lo    <= '0;
            r_state <= S_HI;
          end else if (w_enter) begin
            r_lo      <= switches;
            r_operand <= {r_hi, switches};
            r_valid   <= 1'b1;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          if (w_back || w_enter) begin
            r_hi    <= '0;
            r_lo    <= '0;
            r_state <= S_HI;
          end
        end
        default: begin
          r_hi    <= '0;
          r_lo    <= '0;
          r_state <= S_HI;
        end
      endcase
    end
  end

  // In S_DONE the working low digit always equals operand[3:0].
  always_comb begin
    disp_hi = '0;
    disp_lo = '0;
    case (r_state)
      S_HI:    disp_hi = switches;
      S_LO:    begin disp_hi = r_hi;           disp_lo = switches; end
      S_DONE:  begin disp_hi = r_operand[7:4]; disp_lo = r_lo;     end
      default: ;
    endcase
  end

  assign operand       = r_operand;
  assign operand_valid = r_valid;
  assign state         = r_state;

endmodule

// File: tb/tb_operand_entry.sv
// Bench for operand_entry with a short debounce; committed operands are
// scoreboarded against operand_valid pulses.
module tb_operand_entry;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [1:0] buttons;
  logic [3:0] switches;
  logic [7:0] operand;
  logic       operand_valid;
  logic [1:0] state;
  logic [3:0] disp_hi, disp_lo;

  int total = 0;
  int bad   = 0;
  int vcnt  = 0;
  int v0;
  logic [7:0] sb_q[$];

  operand_entry #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .clock(clock), .reset_n(reset_n), .buttons(buttons), .switches(switches),
    .operand(operand), .operand_valid(operand_valid), .state(state),
    .disp_hi(disp_hi), .disp_lo(disp_lo)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h @%0t", tag, act, exp, $time);
    end
  endtask

  // Scoreboard: every valid pulse must match the oldest pushed operand.
  always @(negedge clock) begin
    if (reset_n && operand_valid) begin
      vcnt++;
      if (sb_q.size() == 0) chk("unexp_valid", 32'd1, 32'd0);
      else                  chk("sb_operand", {24'd0, operand}, {24'd0, sb_q.pop_front()});
    end
  end

  task automatic press(input logic [1:0] mask, input int hold);
    @(negedge clock);
    buttons = buttons & ~mask;
    repeat (hold) @(posedge clock);
    @(negedge clock);
    buttons = 2'b11;
    repeat (10) @(negedge clock);
  endtask

  initial begin
    reset_n  = 1'b0;
    buttons  = 2'b11;
    switches = 4'h0;
    repeat (3) @(negedge clock);
    chk("rst_state", {30'd0, state}, 32'd0);
    chk("rst_operand", {24'd0, operand}, 32'd0);
    chk("rst_valid", {31'd0, operand_valid}, 32'd0);
    chk("rst_disp_lo", {28'd0, disp_lo}, 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // basic entry A3
    switches = 4'hA;
    press(2'b01, 8);
    chk("t1_state_lo", {30'd0, state}, 32'd1);
    chk("t1_disp_hi_lo", {28'd0, disp_hi}, 32'hA);
    switches = 4'h3;
    v0 = vcnt;
    sb_q.push_back(8'hA3);
    press(2'b01, 8);
    chk("t1_operand", {24'd0, operand}, 32'hA3);
    chk("t1_state_done", {30'd0, state}, 32'd2);
    chk("t1_disp_hi", {28'd0, disp_hi}, 32'hA);
    chk("t1_disp_lo", {28'd0, disp_lo}, 32'h3);
    chk("t1_one_valid", vcnt - v0, 32'd1);
    press(2'b01, 8);
    chk("t1_back_to_hi", {30'd0, state}, 32'd0);

    // glitch then exact latency
    press(2'b01, 3);
    chk("t2_glitch_state", {30'd0, state}, 32'd0);
    switches = 4'h6;
    @(negedge clock);
    buttons[0] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clock);
      #1;
      if (k == 5) chk("t2_before_E6", {30'd0, state}, 32'd0);
      if (k == 6) chk("t2_at_E6", {30'd0, state}, 32'd1);
    end
    @(negedge clock);
    buttons = 2'b11;
    repeat (10) @(negedge clock);
    chk("t2_no_repeat", {30'd0, state}, 32'd1);
    chk("t2_disp_hi", {28'd0, disp_hi}, 32'h6);

    // BACK from S_LO with hi=5
    press(2'b10, 8);
    switches = 4'h5;
    press(2'b01, 8);
    chk("t3_in_lo", {30'd0, state}, 32'd1);
    chk("t3_hi5", {28'd0, disp_hi}, 32'h5);
    press(2'b10, 8);
    chk("t3_state", {30'd0, state}, 32'd0);
    chk("t3_operand", {24'd0, operand}, 32'hA3);
    switches = 4'hF;
    press(2'b10, 0);
    chk("t3_disp_live", {28'd0, disp_hi}, 32'hF);

    // simultaneous ENTER+BACK in S_HI
    switches = 4'h9;
    v0 = vcnt;
    press(2'b11, 8);
    chk("t4_state", {30'd0, state}, 32'd0);
    chk("t4_no_valid", vcnt - v0, 32'd0);
    chk("t4_disp_lo", {28'd0, disp_lo}, 32'd0);

    // enter 7E then ENTER from S_DONE
    switches = 4'h7;
    press(2'b01, 8);
    switches = 4'hE;
    sb_q.push_back(8'h7E);
    press(2'b01, 8);
    chk("t5_operand", {24'd0, operand}, 32'h7E);
    chk("t5_done", {30'd0, state}, 32'd2);
    switches = 4'hC;
    v0 = vcnt;
    press(2'b01, 8);
    chk("t5_state", {30'd0, state}, 32'd0);
    chk("t5_disp_hi", {28'd0, disp_hi}, 32'hC);
    chk("t5_keep_op", {24'd0, operand}, 32'h7E);
    chk("t5_no_valid", vcnt - v0, 32'd0);

    // reset mid-debounce in S_LO
    switches = 4'h1;
    press(2'b01, 8);
    chk("t6_in_lo", {30'd0, state}, 32'd1);
    @(negedge clock);
    buttons[0] = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b0;
    #1;
    chk("t6_rst_state", {30'd0, state}, 32'd0);
    chk("t6_rst_operand", {24'd0, operand}, 32'd0);
    chk("t6_rst_valid", {31'd0, operand_valid}, 32'd0);
    @(negedge clock);
    buttons = 2'b11;
    @(negedge clock);
    reset_n = 1'b1;
    repeat (20) @(negedge clock);
    chk("t6_no_event", {30'd0, state}, 32'd0);

    // button held across reset release yields one event
    switches = 4'h4;
    reset_n = 1'b0;
    buttons[0] = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (12) @(negedge clock);
    chk("t6_held_event", {30'd0, state}, 32'd1);
    chk("t6_held_hi", {28'd0, disp_hi}, 32'h4);
    buttons = 2'b11;
    repeat (10) @(negedge clock);

    chk("sb_empty", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
